// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter:
//     cpu_*  pipeline MEM-stage requester (load/store, stall back-pressure)
//     dbg_*  debug / program-loader requester (grant handshake, lock)
//     mem_*  single-port synchronous 64-bit data-memory array
//   slave  : arbiter view (takes requests, drives memory)
//   master : requester/memory-side view (drives requests, memory read data)
//   With MISALIGN_TRAP_EN defined the bundle carries cpu_misalign.
interface dmem_arbiter_if #(parameter int DEPTH_LOG2 = 8);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [63:0]           cpu_addr;
  logic [63:0]           cpu_wdata;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [63:0]           cpu_rdata;
`ifdef MISALIGN_TRAP_EN
  logic                  cpu_misalign;
`endif
  logic                  dbg_req;
  logic                  dbg_we;
  logic                  dbg_lock;
  logic [63:0]           dbg_addr;
  logic [63:0]           dbg_wdata;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [63:0]           dbg_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [63:0]           mem_wdata;
  logic [63:0]           mem_rdata;

  modport slave (
`ifdef MISALIGN_TRAP_EN
    output cpu_misalign,
`endif
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
`ifdef MISALIGN_TRAP_EN
    input  cpu_misalign,
`endif
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port 64-bit data memory between the pipeline MEM stage
//   (cpu_*, priority requester) and a debug/program loader (dbg_*).
//   A starvation counter forces a loader grant after MAX_WAIT denied cycles;
//   dbg_lock lets the loader keep ownership across a burst.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  dmem_arbiter_if.slave: cpu requests/stall/read return, loader
//        requests/grant/read return, memory strobe/address/data.
// Grants and memory drive are combinational; owner state, starvation
// counter and read-return valids are registered.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses are granted
// but suppressed; cpu ones raise cpu_misalign for that cycle).
module dmem_arbiter #(
  parameter int DEPTH_LOG2 = 8,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_W      = 3
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;

  logic                  cpu_gnt, dbg_gnt;
  logic                  cpu_ok, dbg_ok;
  logic                  mem_en, mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [63:0]           mem_wdata;

  // Address bits outside the word index only matter for the optional trap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cpu_addr[63:DEPTH_LOG2+3], bus.cpu_addr[2:0],
                              bus.dbg_addr[63:DEPTH_LOG2+3], bus.dbg_addr[2:0]};

  always_comb begin
    cpu_ok = 1'b1;
    dbg_ok = 1'b1;
`ifdef MISALIGN_TRAP_EN
    cpu_ok = (bus.cpu_addr[2:0] == 3'b000);
    dbg_ok = (bus.dbg_addr[2:0] == 3'b000);
`endif
  end

  always_comb begin
    // A locked loader keeps the memory; otherwise the cpu has priority
    // unless the loader has waited long enough.
    if (state_q == LOCK && bus.dbg_req && bus.dbg_lock)
      dbg_gnt = 1'b1;
    else
      dbg_gnt = bus.dbg_req && (!bus.cpu_req || wait_cnt_q == WAIT_SAT);
    dbg_gnt = dbg_gnt && !rst;
    cpu_gnt = bus.cpu_req && !dbg_gnt && !rst;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt && cpu_ok) begin
      mem_en    = 1'b1;
      mem_we    = bus.cpu_we;
      mem_addr  = bus.cpu_addr[DEPTH_LOG2+2:3];
      mem_wdata = bus.cpu_wdata;
    end else if (dbg_gnt && dbg_ok) begin
      mem_en    = 1'b1;
      mem_we    = bus.dbg_we;
      mem_addr  = bus.dbg_addr[DEPTH_LOG2+2:3];
      mem_wdata = bus.dbg_wdata;
    end

    // LOCK exit is handled by the same grant logic: a cycle without a
    // locked request is arbitrated normally and returns to ARB.
    state_d = (dbg_gnt && bus.dbg_lock) ? LOCK : ARB;

    wait_cnt_d = '0;
    if (bus.dbg_req && !dbg_gnt)
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;

    cpu_rvalid_d = cpu_gnt && cpu_ok && !bus.cpu_we;
    dbg_rvalid_d = dbg_gnt && dbg_ok && !bus.dbg_we;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt && !rst;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : 64'd0;
  assign bus.dbg_rdata  = dbg_rvalid_q ? bus.mem_rdata : 64'd0;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
`ifdef MISALIGN_TRAP_EN
  assign bus.cpu_misalign = cpu_gnt && !cpu_ok;
`endif
endmodule
